// File: rtl/tlm_frame_sched.sv
// ----------------------------------------------------------------------------
// tlm_frame_sched
//
// Frame scheduler for the UART telemetry sequencer. It runs one waveform
// frame at a time:
//   1. flush the waveform FIFO,
//   2. enable ADC capture until the FIFO reports almost-full,
//   3. latch the frame timestamp and pulse the sequencer start strobe,
//   4. wait for the sequencer's send-end pulse,
//   5. hold off for GAP_CYCLES before arming the next capture.
// Frames repeat forever in auto mode. In single-shot mode each SINGLE_REQ
// produces one frame. Capture and transmit both have watchdogs that park the
// scheduler in ERROR until ERR_CLR.
//
// Parameters
//   GAP_CYCLES   holdoff cycles between SEND_END and the next capture arm (>=1)
//   TX_TIMEOUT   max cycles spent in SEND before the transmit watchdog fires
//   CAP_TIMEOUT  max cycles spent in CAPTURE before the capture watchdog fires
//   CNT_W        width of the shared gap/watchdog counter
//
// Ports
//   CLK          system clock
//   RESET        asynchronous, active-low reset
//   ENABLE       level; 0 stops scheduling at the next frame boundary
//   MODE_AUTO    1 = free-running, 0 = single-shot
//   SINGLE_REQ   one-cycle pulse requesting one frame (single-shot mode)
//   ERR_CLR      one-cycle pulse; clears sticky errors, leaves ERROR
//   FIFO_AFF     waveform FIFO almost-full (frame data ready)
//   FIFO_EF      waveform FIFO empty (informational only)
//   TX_SEND_END  one-cycle pulse from the sequencer at end of frame
//   TIME_NOW     free-running time counter
//   FIFO_CLR     one-cycle FIFO flush pulse
//   FIFO_WR_ENA  ADC-to-FIFO write enable (level)
//   TX_STR       one-cycle frame start strobe to the sequencer
//   TIME_LAT     TIME_NOW as seen during the TX_STR cycle
//   BUSY         high in every state except IDLE and ERROR
//   FRAME_CNT    completed frames, wraps 0xFFFF -> 0x0000
//   TX_TO_ERR    sticky: transmit watchdog expired
//   CAP_TO_ERR   sticky: capture watchdog expired
//
// Handshakes: every strobe in and out of this block is a single-cycle pulse
// sampled on posedge CLK; FIFO_AFF/FIFO_EF/ENABLE/MODE_AUTO are levels sampled
// on posedge CLK. There is no back-pressure in either direction.
// ----------------------------------------------------------------------------
module tlm_frame_sched #(
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned TX_TIMEOUT  = 5000000,
    parameter int unsigned CAP_TIMEOUT = 1000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        MODE_AUTO,
    input  logic        SINGLE_REQ,
    input  logic        ERR_CLR,
    input  logic        FIFO_AFF,
    input  logic        FIFO_EF,
    input  logic        TX_SEND_END,
    input  logic [39:0] TIME_NOW,
    output logic        FIFO_CLR,
    output logic        FIFO_WR_ENA,
    output logic        TX_STR,
    output logic [39:0] TIME_LAT,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic        TX_TO_ERR,
    output logic        CAP_TO_ERR
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_START   = 3'd3,
        S_SEND    = 3'd4,
        S_GAP     = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    // Terminal counts: each counted state lasts exactly N cycles, so the
    // decision is taken while the counter holds N-1.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [39:0]       time_lat_q, time_lat_d;
    logic              tx_to_err_q, tx_to_err_d;
    logic              cap_to_err_q, cap_to_err_d;
    logic              fifo_clr_q;
    logic              fifo_wr_ena_q;
    logic              tx_str_q;
    logic              busy_q;

    // Whether a new frame should be armed at an IDLE/GAP decision point.
    // MODE_AUTO is only looked at here, so a mode change lands at the next
    // frame boundary.
    logic go_frame;
    assign go_frame = ENABLE && (MODE_AUTO || pend_q);

    // FIFO_EF carries no control meaning: starting a frame on an empty FIFO
    // simply makes the sequencer send stale data.
    logic unused_fifo_ef;
    assign unused_fifo_ef = FIFO_EF;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        time_lat_d   = time_lat_q;
        // A request is remembered in any state, but only while enabled.
        pend_d       = pend_q | (SINGLE_REQ & ENABLE);
        // ERR_CLR clears the sticky flags wherever it arrives; a watchdog
        // firing in the same cycle below still wins.
        tx_to_err_d  = tx_to_err_q  & ~ERR_CLR;
        cap_to_err_d = cap_to_err_q & ~ERR_CLR;

        case (state_q)
            S_IDLE: begin
                if (go_frame) begin
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                cnt_d   = '0;
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                cnt_d = cnt_q + 1'b1;
                // Data-ready takes priority over the watchdog.
                if (FIFO_AFF) begin
                    state_d = S_START;
                end else if (cnt_q == CAP_LAST) begin
                    cap_to_err_d = 1'b1;
                    state_d      = S_ERROR;
                end
            end

            S_START: begin
                time_lat_d = TIME_NOW;
                cnt_d      = '0;
                state_d    = S_SEND;
            end

            S_SEND: begin
                cnt_d = cnt_q + 1'b1;
                // A send-end arriving on the watchdog's last cycle still
                // counts as a completed frame.
                if (TX_SEND_END) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end else if (cnt_q == TX_LAST) begin
                    tx_to_err_d = 1'b1;
                    state_d     = S_ERROR;
                end
            end

            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = go_frame ? S_FLUSH : S_IDLE;
                end
            end

            S_ERROR: begin
                if (ERR_CLR) begin
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The request that starts a frame is consumed as FLUSH is entered.
        if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
            pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Strobes/levels are decoded from the next
    // state so each output is a flop that tracks the current state exactly.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            frame_cnt_q   <= 16'd0;
            time_lat_q    <= 40'd0;
            tx_to_err_q   <= 1'b0;
            cap_to_err_q  <= 1'b0;
            fifo_clr_q    <= 1'b0;
            fifo_wr_ena_q <= 1'b0;
            tx_str_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            frame_cnt_q   <= frame_cnt_d;
            time_lat_q    <= time_lat_d;
            tx_to_err_q   <= tx_to_err_d;
            cap_to_err_q  <= cap_to_err_d;
            fifo_clr_q    <= (state_d == S_FLUSH);
            fifo_wr_ena_q <= (state_d == S_CAPTURE);
            tx_str_q      <= (state_d == S_START);
            busy_q        <= !((state_d == S_IDLE) || (state_d == S_ERROR));
        end
    end

    assign FIFO_CLR    = fifo_clr_q;
    assign FIFO_WR_ENA = fifo_wr_ena_q;
    assign TX_STR      = tx_str_q;
    assign TIME_LAT    = time_lat_q;
    assign BUSY        = busy_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign TX_TO_ERR   = tx_to_err_q;
    assign CAP_TO_ERR  = cap_to_err_q;

endmodule

// File: tb/tb_tlm_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_tlm_frame_sched
//
// Directed bench for tlm_frame_sched with short parameters
// (GAP_CYCLES=10, CAP_TIMEOUT=60, TX_TIMEOUT=120). A responder process plays
// the FIFO and sequencer: it raises FIFO_AFF on capture cycle cap_dly and
// pulses TX_SEND_END on SEND cycle send_dly (0 = never), and it records strobe
// counts, strobe spacing and the expected timestamp of every frame.
// ----------------------------------------------------------------------------
module tb_tlm_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        mode_auto = 1'b0;
  logic        single_req = 1'b0;
  logic        err_clr = 1'b0;
  logic        fifo_aff = 1'b0;
  logic        fifo_ef = 1'b0;
  logic        tx_send_end = 1'b0;
  logic [39:0] time_now = 40'd100;

  logic        fifo_clr;
  logic        fifo_wr_ena;
  logic        tx_str;
  logic [39:0] time_lat;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        tx_to_err;
  logic        cap_to_err;

  // scoreboard / monitor state
  int pass_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int fifo_clr_cnt = 0;
  int tx_str_cnt = 0;
  int last_str_cyc = 0;
  int str_period = 0;
  int cap_cnt = 0;
  int cap_len = 0;
  int send_cnt = 0;
  int to_lat = 0;
  int cap_dly = 50;
  int send_dly = 100;
  logic in_send = 1'b0;
  logic to_prev = 1'b0;
  logic [39:0] exp_q[$];

  tlm_frame_sched #(
    .GAP_CYCLES (10),
    .TX_TIMEOUT (120),
    .CAP_TIMEOUT(60),
    .CNT_W      (8)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .ENABLE     (enable),
    .MODE_AUTO  (mode_auto),
    .SINGLE_REQ (single_req),
    .ERR_CLR    (err_clr),
    .FIFO_AFF   (fifo_aff),
    .FIFO_EF    (fifo_ef),
    .TX_SEND_END(tx_send_end),
    .TIME_NOW   (time_now),
    .FIFO_CLR   (fifo_clr),
    .FIFO_WR_ENA(fifo_wr_ena),
    .TX_STR     (tx_str),
    .TIME_LAT   (time_lat),
    .BUSY       (busy),
    .FRAME_CNT  (frame_cnt),
    .TX_TO_ERR  (tx_to_err),
    .CAP_TO_ERR (cap_to_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- global time limit ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "time limit");
  end

  // ---------------- FIFO / sequencer responder and monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      time_now = time_now + 40'd1;
      fifo_aff = 1'b0;
      tx_send_end = 1'b0;
      if (fifo_clr) fifo_clr_cnt++;
      if (tx_str) begin
        tx_str_cnt++;
        str_period = cyc - last_str_cyc;
        last_str_cyc = cyc;
        // value on TIME_NOW at the edge that closes the TX_STR cycle
        exp_q.push_back(time_now);
        in_send = 1'b1;
        send_cnt = 0;
      end else if (in_send && busy) begin
        send_cnt++;
        if (send_dly != 0 && send_cnt == send_dly) begin
          tx_send_end = 1'b1;
          in_send = 1'b0;
        end
      end else begin
        in_send = 1'b0;
      end
      if (fifo_wr_ena) begin
        cap_cnt++;
        if (cap_dly != 0 && cap_cnt == cap_dly) fifo_aff = 1'b1;
      end else if (cap_cnt != 0) begin
        cap_len = cap_cnt;
        cap_cnt = 0;
      end
      if (tx_to_err && !to_prev) to_lat = cyc - last_str_cyc;
      to_prev = tx_to_err;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_single();
    single_req = 1'b1;
    step();
    single_req = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy !== val && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 64'(busy), 64'(val));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int e_fr;
    int e_str;
    int e_clr;

    // reset
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_fifo_clr", 64'(fifo_clr), 64'(1'b0));
    check("rst_wr_ena", 64'(fifo_wr_ena), 64'(1'b0));
    check("rst_tx_str", 64'(tx_str), 64'(1'b0));
    check("rst_time_lat", 64'(time_lat), 64'(40'd0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(16'd0));
    check("rst_errs", 64'({tx_to_err, cap_to_err}), 64'(2'b00));
    rst_n = 1'b1;
    step();
    step();
    check("idle_disabled", 64'(busy), 64'(1'b0));

    // request while disabled is not remembered
    pulse_single();
    enable = 1'b1;
    repeat (5) step();
    check("req_disabled_busy", 64'(busy), 64'(1'b0));
    check("req_disabled_clr", 64'(fifo_clr_cnt), 64'(0));

    // free-running: 50-cycle capture, 100-cycle send, 10-cycle gap
    mode_auto = 1'b1;
    step();
    check("auto_flush", 64'({fifo_clr, busy}), 64'(2'b11));
    step();
    check("auto_capture", 64'({fifo_clr, fifo_wr_ena}), 64'(2'b01));
    n = 0;
    while (frame_cnt != 16'd3 && n < 1000) begin
      step();
      n++;
    end
    check("auto_frames3", 64'(frame_cnt), 64'(16'd3));
    check("auto_str_cnt", 64'(tx_str_cnt), 64'(3));
    check("auto_period", 64'(str_period), 64'(162));
    check("auto_cap_len", 64'(cap_len), 64'(50));
    check("auto_time_lat", 64'(time_lat), 64'(exp_q[$]));

    // ENABLE dropped during SEND: frame 4 finishes, then idle
    n = 0;
    while (tx_str_cnt != 4 && n < 200) begin
      step();
      n++;
    end
    check("auto_str4", 64'(tx_str_cnt), 64'(4));
    repeat (10) step();
    enable = 1'b0;
    wait_busy(1'b0, 300, "endis_idle");
    check("endis_frames", 64'(frame_cnt), 64'(16'd4));
    check("endis_period", 64'(str_period), 64'(162));
    check("endis_time_lat", 64'(time_lat), 64'(exp_q[$]));
    repeat (20) step();
    check("endis_no_clr", 64'(fifo_clr_cnt), 64'(4));

    // single-shot: one request -> one frame
    mode_auto = 1'b0;
    enable = 1'b1;
    e_fr = 4;
    e_str = 4;
    pulse_single();
    wait_busy(1'b1, 10, "single_start");
    wait_busy(1'b0, 400, "single_done");
    e_fr++;
    e_str++;
    check("single_str", 64'(tx_str_cnt), 64'(e_str));
    check("single_frames", 64'(frame_cnt), 64'(e_fr));
    repeat (20) step();
    check("single_no_more", 64'(tx_str_cnt), 64'(e_str));

    // second request during SEND -> exactly one more frame after GAP
    pulse_single();
    n = 0;
    while (tx_str_cnt != e_str + 1 && n < 200) begin
      step();
      n++;
    end
    check("req2_str", 64'(tx_str_cnt), 64'(e_str + 1));
    repeat (10) step();
    pulse_single();
    wait_busy(1'b0, 800, "req2_done");
    e_fr += 2;
    e_str += 2;
    check("req2_str_total", 64'(tx_str_cnt), 64'(e_str));
    check("req2_frames", 64'(frame_cnt), 64'(e_fr));
    repeat (20) step();
    check("req2_no_more", 64'(tx_str_cnt), 64'(e_str));

    // capture watchdog
    cap_dly = 0;
    pulse_single();
    n = 0;
    while (cap_to_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("capto_flag", 64'(cap_to_err), 64'(1'b1));
    check("capto_wr_ena", 64'(fifo_wr_ena), 64'(1'b0));
    check("capto_busy", 64'(busy), 64'(1'b0));
    check("capto_len", 64'(cap_len), 64'(60));
    check("capto_no_str", 64'(tx_str_cnt), 64'(e_str));
    e_clr = fifo_clr_cnt;
    // ERROR ignores requests; ERR_CLR drops the pending one
    pulse_single();
    repeat (5) step();
    check("err_hold", 64'({busy, cap_to_err}), 64'(2'b01));
    check("err_hold_clr", 64'(fifo_clr_cnt), 64'(e_clr));
    pulse_err_clr();
    check("errclr_flag", 64'(cap_to_err), 64'(1'b0));
    repeat (10) step();
    check("errclr_idle", 64'(busy), 64'(1'b0));
    check("errclr_no_pend", 64'(fifo_clr_cnt), 64'(e_clr));

    // AFF on the last capture cycle wins over the watchdog
    cap_dly = 60;
    pulse_single();
    wait_busy(1'b1, 10, "capedge_start");
    wait_busy(1'b0, 400, "capedge_done");
    e_fr++;
    e_str++;
    check("capedge_flag", 64'(cap_to_err), 64'(1'b0));
    check("capedge_len", 64'(cap_len), 64'(60));
    check("capedge_frames", 64'(frame_cnt), 64'(e_fr));

    // transmit watchdog
    cap_dly = 50;
    send_dly = 0;
    pulse_single();
    n = 0;
    while (tx_to_err !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    e_str++;
    check("txto_flag", 64'(tx_to_err), 64'(1'b1));
    check("txto_busy", 64'(busy), 64'(1'b0));
    check("txto_frames", 64'(frame_cnt), 64'(e_fr));
    check("txto_latency", 64'(to_lat), 64'(121));
    pulse_err_clr();
    check("txto_clr", 64'(tx_to_err), 64'(1'b0));

    // send-end on the watchdog's last cycle wins; empty FIFO is harmless
    send_dly = 120;
    fifo_ef = 1'b1;
    pulse_single();
    wait_busy(1'b1, 10, "txedge_start");
    wait_busy(1'b0, 500, "txedge_done");
    fifo_ef = 1'b0;
    e_fr++;
    e_str++;
    check("txedge_flags", 64'({tx_to_err, cap_to_err}), 64'(2'b00));
    check("txedge_frames", 64'(frame_cnt), 64'(e_fr));
    check("txedge_str", 64'(tx_str_cnt), 64'(e_str));

    // asynchronous reset in the middle of CAPTURE
    send_dly = 100;
    pulse_single();
    n = 0;
    while (fifo_wr_ena !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("arst_in_capture", 64'(fifo_wr_ena), 64'(1'b1));
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr_ena", 64'(fifo_wr_ena), 64'(1'b0));
    check("arst_busy", 64'(busy), 64'(1'b0));
    check("arst_frame_cnt", 64'(frame_cnt), 64'(16'd0));
    check("arst_time_lat", 64'(time_lat), 64'(40'd0));
    check("arst_strobes", 64'({fifo_clr, tx_str, tx_to_err, cap_to_err}), 64'(4'b0000));
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("arst_after_idle", 64'(busy), 64'(1'b0));

    // frame counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    step();
    release dut.frame_cnt_q;
    step();
    check("wrap_preload", 64'(frame_cnt), 64'(16'hFFFE));
    pulse_single();
    wait_busy(1'b1, 10, "wrap1_start");
    wait_busy(1'b0, 400, "wrap1_done");
    check("wrap_ffff", 64'(frame_cnt), 64'(16'hFFFF));
    pulse_single();
    wait_busy(1'b1, 10, "wrap2_start");
    wait_busy(1'b0, 400, "wrap2_done");
    check("wrap_zero", 64'(frame_cnt), 64'(16'h0000));
    check("wrap_time_lat", 64'(time_lat), 64'(exp_q[$]));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tlm_frame_sched.md
Name: tlm_frame_sched

Overview:
Frame scheduler for the UART telemetry sequencer. Sequences each waveform frame: arms ADC capture into the waveform FIFO, waits for FIFO almost-full, latches the frame timestamp, pulses the sequencer start strobe, waits for send-end, then enforces an inter-frame holdoff. Supports free-running and single-shot modes, a transmit watchdog, and a frame counter for housekeeping readout.

Parameters:
GAP_CYCLES, 1000, holdoff cycles between SEND_END and the next capture arm (min 1)
TX_TIMEOUT, 5000000, max CLK cycles from TX_STR to TX_SEND_END (one 1036-byte frame at 115200 bd/50 MHz is ~4.5e6)
CAP_TIMEOUT, 1000000, max CLK cycles in CAPTURE before abort
CNT_W, 24, width of gap/watchdog counter (must hold max of the three above)

Ports:
CLK  in  1  system clock (50 MHz)
RESET  in  1  asynchronous, active-low reset
ENABLE  in  1  level; 0 stops scheduling at the next frame boundary
MODE_AUTO  in  1  1 = free-running, 0 = single-shot
SINGLE_REQ  in  1  one-cycle pulse; requests one frame when MODE_AUTO=0
ERR_CLR  in  1  one-cycle pulse; clears sticky errors, leaves ERROR state
FIFO_AFF  in  1  waveform FIFO almost-full (frame data ready)
FIFO_EF  in  1  waveform FIFO empty
TX_SEND_END  in  1  one-cycle pulse from sequencer at end of frame
TIME_NOW  in  40  free-running time counter
FIFO_CLR  out  1  one-cycle FIFO flush pulse
FIFO_WR_ENA  out  1  ADC-to-FIFO write enable (level)
TX_STR  out  1  one-cycle frame start strobe to sequencer
TIME_LAT  out  40  TIME_NOW captured on the TX_STR cycle
BUSY  out  1  1 in any state except IDLE/ERROR
FRAME_CNT  out  16  frames completed, wraps 0xFFFF->0x0000
TX_TO_ERR  out  1  sticky: transmit watchdog expired
CAP_TO_ERR  out  1  sticky: capture timeout expired

Behaviour:
- Reset (RESET=0, async): state IDLE; all outputs 0; internal counter 0; pending-request flag 0.
- All outputs registered; all state changes on posedge CLK.
- States: IDLE, FLUSH, CAPTURE, START, SEND, GAP, ERROR.
- IDLE: go FLUSH when ENABLE=1 and (MODE_AUTO=1 or request pending). SINGLE_REQ seen in any state sets pending; cleared on entry to FLUSH. SINGLE_REQ while ENABLE=0 is ignored (not latched).
- FLUSH (1 cycle): FIFO_CLR=1, counter cleared -> CAPTURE.
- CAPTURE: FIFO_WR_ENA=1, counter increments. FIFO_AFF=1 -> START, FIFO_WR_ENA drops the same edge. Counter reaching CAP_TIMEOUT-1 without AFF -> set CAP_TO_ERR, FIFO_WR_ENA=0, -> ERROR. AFF wins if both in the same cycle.
- START (1 cycle): TX_STR=1, TIME_LAT<=TIME_NOW, counter cleared -> SEND. TX_STR is high exactly one cycle per frame.
- SEND: counter increments. TX_SEND_END=1 -> FRAME_CNT+1, counter cleared -> GAP. Counter reaching TX_TIMEOUT-1 -> set TX_TO_ERR -> ERROR. SEND_END wins if both in the same cycle. TX_SEND_END outside SEND is ignored.
- GAP: counter increments; at GAP_CYCLES-1 -> FLUSH if ENABLE=1 and (MODE_AUTO=1 or pending), else IDLE.
- ENABLE falling mid-frame does not abort: the frame completes through GAP, then IDLE.
- ERROR: BUSY=0, FIFO_WR_ENA=0, no TX_STR. Stays until ERR_CLR=1 -> errors cleared, pending cleared -> IDLE. ERR_CLR in other states clears only the sticky flags.
- FIFO_EF is informational: FIFO_EF=1 in START is not an error (sequencer sends stale data).
- Reset asserted mid-frame: immediate return to reset values; FRAME_CNT resets to 0.
- MODE_AUTO changes take effect at the next IDLE/GAP decision.

Test Plan:
- Auto mode, GAP_CYCLES=10, AFF after 50 cycles of capture, SEND_END 100 cycles after TX_STR -> FIFO_CLR, TX_STR pulses at a fixed period of 1+50+1+100+10 cycles (excluding the last counted-cycle edges). FRAME_CNT=3 after 3 frames. TIME_LAT equals TIME_NOW at each TX_STR.
- Single-shot: MODE_AUTO=0, SINGLE_REQ once -> exactly one TX_STR, then IDLE with BUSY=0. A second SINGLE_REQ during SEND -> exactly one further frame after GAP.
- Capture timeout: CAP_TIMEOUT=20, FIFO_AFF held 0 -> CAP_TO_ERR=1 at cycle 20 of CAPTURE, FIFO_WR_ENA=0, ERROR. ERR_CLR -> IDLE, flag 0.
- TX watchdog: TX_TIMEOUT=30, no SEND_END -> TX_TO_ERR=1, FRAME_CNT unchanged. SEND_END and timeout on the same cycle -> GAP, no error.
- ENABLE dropped during SEND -> frame completes, FRAME_CNT+1, IDLE after GAP, no further FIFO_CLR.
- Preload FRAME_CNT=0xFFFF via 65535 frames (GAP_CYCLES=1, shortcut stimulus) -> wraps to 0x0000. Reset pulse during CAPTURE -> all outputs 0 asynchronously.
